// File: rtl/shim_sample_pkg.sv
// Shared constants, state encoding and slice helper for the sample collector.
package shim_sample_pkg;

    localparam int N_CH     = 8;
    localparam int SAMPLE_W = 16;
    localparam int MAG_W    = SAMPLE_W - 1;
    localparam int CH_W     = $clog2(N_CH);
    localparam int CAT_W    = N_CH * MAG_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        ERROR   = 2'd2
    } state_t;

    // LSB position of channel ch inside the concatenated magnitude bus.
    function automatic int ch_lsb(input int ch);
        return ch * MAG_W;
    endfunction

endpackage

// File: rtl/shim_abs_sat.sv
// Signed sample to saturated magnitude. The most negative code has no
// positive counterpart in MAG_W bits, so it clamps to all-ones and flags it.
module shim_abs_sat
    import shim_sample_pkg::*;
(
    input  logic [SAMPLE_W-1:0] data,
    output logic [MAG_W-1:0]    mag,
    output logic                sat
);

    // Two's-complement negate only needs the low MAG_W bits for in-range values.
    always_comb begin
        mag = data[MAG_W-1:0];
        sat = 1'b0;
        if (data[SAMPLE_W-1]) begin
            if (data[MAG_W-1:0] == '0) begin
                mag = '1;
                sat = 1'b1;
            end else begin
                mag = MAG_W'(~data[MAG_W-1:0] + MAG_W'(1));
            end
        end
    end

endmodule

// File: rtl/shim_abs_sample_collector.sv
// Collects one magnitude per channel and publishes a full frame atomically.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | not collecting; mask and timer cleared, waiting for enable
//   COLLECT | accepting samples, staging them until all channels present
//   ERROR   | duplicate channel or frame timeout seen; held until rst
//
// A sample offered on the edge where enable falls is accepted by the
// handshake (sample_ready was high) but discarded; producers must treat it
// as lost.
module shim_abs_sample_collector
    import shim_sample_pkg::*;
#(
    parameter int TIMEOUT = 1024
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                sample_valid,
    input  logic [CH_W-1:0]     sample_ch,
    input  logic [SAMPLE_W-1:0] sample_data,
    output logic                sample_ready,
    output logic [CAT_W-1:0]    abs_sample_concat,
    output logic                frame_strobe,
    output logic                first_frame_done,
    output logic                sat_seen,
    output logic                err_dup_ch,
    output logic                err_timeout
);

    localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_t              state;
    state_t              state_nxt;
    logic [N_CH-1:0]     mask;
    logic [MAG_W-1:0]    staging [N_CH];
    logic [TMR_W-1:0]    timer;

    logic [MAG_W-1:0]    mag;
    logic                sat;
    logic                take;
    logic                dup_hit;
    logic                complete;
    logic                timeout_hit;
    logic [N_CH-1:0]     ch_onehot;
    logic [CAT_W-1:0]    commit_cat;

    shim_abs_sat u_abs_sat (
        .data (sample_data),
        .mag  (mag),
        .sat  (sat)
    );

    assign sample_ready = (state == COLLECT);

    // Per-edge event decode; dup beats commit beats timeout.
    always_comb begin
        ch_onehot   = N_CH'(1) << sample_ch;
        take        = sample_valid & sample_ready & enable;
        dup_hit     = take & mask[sample_ch];
        complete    = take & ~dup_hit & (&(mask | ch_onehot));
        timeout_hit = sample_ready & enable & (mask != '0)
                    & (timer == TMR_W'(TIMEOUT - 1)) & ~complete & ~dup_hit;
    end

    // Frame image for commit: staged values with the live sample spliced in.
    always_comb begin
        commit_cat = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (sample_ch == CH_W'(i)) begin
                commit_cat[ch_lsb(i) +: MAG_W] = mag;
            end else begin
                commit_cat[ch_lsb(i) +: MAG_W] = staging[i];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt = COLLECT;
                end
            end
            COLLECT: begin
                if (!enable) begin
                    state_nxt = IDLE;
                end else if (dup_hit || timeout_hit) begin
                    state_nxt = ERROR;
                end
            end
            ERROR: begin
                state_nxt = ERROR;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Mask, staging, timer, committed frame and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask              <= '0;
            timer             <= '0;
            abs_sample_concat <= '0;
            frame_strobe      <= 1'b0;
            first_frame_done  <= 1'b0;
            sat_seen          <= 1'b0;
            err_dup_ch        <= 1'b0;
            err_timeout       <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                staging[i] <= '0;
            end
        end else begin
            frame_strobe <= 1'b0;
            if (state == COLLECT) begin
                if (!enable) begin
                    mask             <= '0;
                    timer            <= '0;
                    first_frame_done <= 1'b0;
                end else if (dup_hit) begin
                    err_dup_ch <= 1'b1;
                end else if (complete) begin
                    abs_sample_concat <= commit_cat;
                    frame_strobe      <= 1'b1;
                    first_frame_done  <= 1'b1;
                    mask              <= '0;
                    timer             <= '0;
                    sat_seen          <= sat_seen | sat;
                end else begin
                    if (take) begin
                        staging[sample_ch] <= mag;
                        mask[sample_ch]    <= 1'b1;
                        sat_seen           <= sat_seen | sat;
                    end
                    if (mask == '0) begin
                        timer <= '0;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                    if (timeout_hit) begin
                        err_timeout <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_shim_abs_sample_collector.sv
// Directed bench for shim_abs_sample_collector (TIMEOUT reduced to 16).
module tb_shim_abs_sample_collector;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         enable = 1'b0;
    logic         sample_valid = 1'b0;
    logic [2:0]   sample_ch = '0;
    logic [15:0]  sample_data = '0;
    logic         sample_ready;
    logic [119:0] abs_sample_concat;
    logic         frame_strobe;
    logic         first_frame_done;
    logic         sat_seen;
    logic         err_dup_ch;
    logic         err_timeout;

    int checks = 0;
    int failures = 0;

    logic [119:0] exp_prev;
    logic [119:0] exp_cat;

    typedef struct {
        logic [2:0]  ch;
        logic [15:0] data;
        logic [14:0] mag;
        int          gap;
    } vec_t;

    vec_t tbl [16];

    shim_abs_sample_collector #(.TIMEOUT(16)) dut (
        .clk               (clk),
        .rst               (rst),
        .enable            (enable),
        .sample_valid      (sample_valid),
        .sample_ch         (sample_ch),
        .sample_data       (sample_data),
        .sample_ready      (sample_ready),
        .abs_sample_concat (abs_sample_concat),
        .frame_strobe      (frame_strobe),
        .first_frame_done  (first_frame_done),
        .sat_seen          (sat_seen),
        .err_dup_ch        (err_dup_ch),
        .err_timeout       (err_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [119:0] act, input logic [119:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] ch, input logic [15:0] d);
        sample_valid = 1'b1;
        sample_ch    = ch;
        sample_data  = d;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
    endtask

    task automatic reset_and_enable();
        rst          = 1'b1;
        enable       = 1'b0;
        sample_valid = 1'b0;
        idle(2);
        rst      = 1'b0;
        exp_prev = '0;
        idle(1);
        enable = 1'b1;
        idle(1);
    endtask

    // Apply eight table rows as one frame, checking no early commit.
    task automatic run_tbl(input int base, input string tag);
        exp_cat = exp_prev;
        for (int k = 0; k < 8; k++) begin
            send(tbl[base+k].ch, tbl[base+k].data);
            exp_cat[int'(tbl[base+k].ch)*15 +: 15] = tbl[base+k].mag;
            if (k < 7) begin
                chk({tag, "_hold"}, abs_sample_concat, exp_prev);
                chk({tag, "_nostrobe"}, frame_strobe, 1'b0);
                idle(tbl[base+k].gap);
            end else begin
                chk({tag, "_concat"}, abs_sample_concat, exp_cat);
                chk({tag, "_strobe"}, frame_strobe, 1'b1);
            end
        end
        idle(1);
        chk({tag, "_strobe_1cyc"}, frame_strobe, 1'b0);
        chk({tag, "_ffd"}, first_frame_done, 1'b1);
        exp_prev = exp_cat;
    endtask

    initial begin
        tbl[0]  = '{3'd0, 16'd100,   15'd100,   0};
        tbl[1]  = '{3'd1, 16'hFF9C,  15'd100,   0};
        tbl[2]  = '{3'd2, 16'd0,     15'd0,     0};
        tbl[3]  = '{3'd3, 16'h7FFF,  15'h7FFF,  0};
        tbl[4]  = '{3'd4, 16'h8001,  15'h7FFF,  0};
        tbl[5]  = '{3'd5, 16'h8000,  15'h7FFF,  0};
        tbl[6]  = '{3'd6, 16'd1,     15'd1,     0};
        tbl[7]  = '{3'd7, 16'hFFFF,  15'd1,     0};
        tbl[8]  = '{3'd7, 16'hFFF9,  15'd7,     2};
        tbl[9]  = '{3'd3, 16'd300,   15'd300,   0};
        tbl[10] = '{3'd0, 16'hFC18,  15'd1000,  5};
        tbl[11] = '{3'd5, 16'd5,     15'd5,     1};
        tbl[12] = '{3'd1, 16'h4000,  15'd16384, 0};
        tbl[13] = '{3'd6, 16'hB1E0,  15'd20000, 0};
        tbl[14] = '{3'd2, 16'd2,     15'd2,     0};
        tbl[15] = '{3'd4, 16'hEEA4,  15'd4444,  0};

        // Reset values.
        idle(2);
        chk("rst_concat", abs_sample_concat, '0);
        chk("rst_ready", sample_ready, 1'b0);
        chk("rst_flags", {frame_strobe, first_frame_done, sat_seen, err_dup_ch, err_timeout}, 5'b0);
        rst = 1'b0;
        exp_prev = '0;
        idle(1);
        chk("idle_ready", sample_ready, 1'b0);
        enable = 1'b1;
        idle(1);
        chk("collect_ready", sample_ready, 1'b1);

        // In-order back-to-back frame with saturation.
        run_tbl(0, "f1");
        chk("f1_sat", sat_seen, 1'b1);

        // Out-of-order frame with idle gaps.
        run_tbl(8, "f2");
        chk("f2_noerr", {err_dup_ch, err_timeout}, 2'b0);

        // Completing accept lands exactly on the timeout edge.
        exp_cat = exp_prev;
        for (int i = 0; i < 7; i++) begin
            send(3'(i), 16'(i * 10 + 1));
            exp_cat[i*15 +: 15] = 15'(i * 10 + 1);
        end
        idle(9);
        send(3'd7, 16'd71);
        exp_cat[7*15 +: 15] = 15'd71;
        chk("tedge_strobe", frame_strobe, 1'b1);
        chk("tedge_concat", abs_sample_concat, exp_cat);
        chk("tedge_noerr", err_timeout, 1'b0);
        chk("tedge_ready", sample_ready, 1'b1);
        exp_prev = exp_cat;

        // Enable drop mid-frame, with a sample pending on the falling edge.
        for (int i = 0; i < 4; i++) send(3'(i), 16'(1000 + i));
        enable = 1'b0;
        send(3'd4, 16'd1004);
        chk("dis_ready", sample_ready, 1'b0);
        chk("dis_ffd", first_frame_done, 1'b0);
        chk("dis_concat", abs_sample_concat, exp_prev);
        idle(3);
        chk("dis_nostrobe", frame_strobe, 1'b0);
        enable = 1'b1;
        idle(1);
        exp_cat = exp_prev;
        for (int i = 0; i < 8; i++) begin
            send(3'(i), 16'(-(2000 + i)));
            exp_cat[i*15 +: 15] = 15'(2000 + i);
            if (i == 6) chk("reen_nostrobe", frame_strobe, 1'b0);
        end
        chk("reen_strobe", frame_strobe, 1'b1);
        chk("reen_concat", abs_sample_concat, exp_cat);
        chk("reen_nodup", err_dup_ch, 1'b0);
        exp_prev = exp_cat;

        // Seven channels then stall: timeout on the 16th edge after first accept.
        for (int i = 0; i < 7; i++) send(3'(i), 16'd5);
        idle(9);
        chk("tmo_before", err_timeout, 1'b0);
        idle(1);
        chk("tmo_flag", err_timeout, 1'b1);
        chk("tmo_ready", sample_ready, 1'b0);
        send(3'd7, 16'd5);
        chk("tmo_hold", abs_sample_concat, exp_prev);

        // Duplicate channel after a good frame.
        reset_and_enable();
        chk("rst2_concat", abs_sample_concat, '0);
        run_tbl(0, "f3");
        send(3'd2, 16'd9);
        chk("dup_first_ok", err_dup_ch, 1'b0);
        send(3'd2, 16'd9);
        chk("dup_flag", err_dup_ch, 1'b1);
        chk("dup_ready", sample_ready, 1'b0);
        chk("dup_concat", abs_sample_concat, exp_prev);
        for (int i = 3; i < 8; i++) send(3'(i), 16'd9);
        chk("dup_hold", abs_sample_concat, exp_prev);
        chk("dup_nostrobe", frame_strobe, 1'b0);

        // Asynchronous reset between edges, mid-frame.
        reset_and_enable();
        run_tbl(8, "f4");
        for (int i = 0; i < 3; i++) send(3'(i), 16'd77);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_concat", abs_sample_concat, '0);
        chk("arst_flags", {sample_ready, frame_strobe, first_frame_done, sat_seen, err_dup_ch, err_timeout}, 6'b0);
        reset_and_enable();
        run_tbl(0, "f5");
        chk("f5_noerr", {err_dup_ch, err_timeout}, 2'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
